// File: rtl/fft_output_serializer.sv
// FFT output serializer: accepts even/odd sample pairs into a circular FIFO and
// streams one {sample, bin index} per cycle. Optional macro FFT_SER_SCALE_EN scales by 1/N.
module fft_output_serializer #(
  parameter int N         = 32,
  parameter int word_size = 16,
  parameter int DEPTH     = 8,
  parameter int AW        = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [2*word_size-1:0] in_samp1,
  input  logic [2*word_size-1:0] in_samp2,
  input  logic [AW-1:0]          in_addr1,
  output logic                   in_ready,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [2*word_size-1:0] m_data,
  output logic [AW-1:0]          m_index,
  output logic                   m_last,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int SW = 2 * word_size;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [SW-1:0] data_mem [DEPTH];
  logic [AW-1:0] idx_mem  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] free_slots;
  logic          push;
  logic          pop;
  logic          drop;
  logic [SW-1:0] store1;
  logic [SW-1:0] store2;
  logic [AW-1:0] addr_odd;

  // Floor-scaling by 2^AW is an arithmetic shift of each signed component.
  function automatic logic [SW-1:0] prep_sample(input logic [SW-1:0] s);
`ifdef FFT_SER_SCALE_EN
    logic signed [word_size-1:0] re;
    logic signed [word_size-1:0] im;
    logic signed [word_size-1:0] re_s;
    logic signed [word_size-1:0] im_s;
    re   = s[SW-1:word_size];
    im   = s[word_size-1:0];
    re_s = re >>> AW;
    im_s = im >>> AW;
    return {re_s, im_s};
`else
    return s;
`endif
  endfunction

  assign free_slots = CW'(DEPTH) - count;
  assign in_ready   = (free_slots >= CW'(2));
  assign push       = in_valid && in_ready;
  assign drop       = in_valid && !in_ready;

  assign m_valid    = (count != '0);
  assign m_data     = data_mem[rd_ptr];
  assign m_index    = idx_mem[rd_ptr];
  assign m_last     = m_valid && (m_index == AW'(N - 1));
  assign pop        = m_valid && m_ready;

  assign store1     = prep_sample(in_samp1);
  assign store2     = prep_sample(in_samp2);
  assign addr_odd   = in_addr1 | AW'(1);

  always_comb begin
    count_nxt = count;
    if (push) count_nxt = count_nxt + CW'(2);
    if (pop)  count_nxt = count_nxt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      count      <= count_nxt;
      frame_done <= pop && m_last;
      if (push) wr_ptr <= wr_ptr + PW'(2);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; count gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem[wr_ptr]          <= store1;
      idx_mem[wr_ptr]           <= in_addr1;
      data_mem[wr_ptr + PW'(1)] <= store2;
      idx_mem[wr_ptr + PW'(1)]  <= addr_odd;
    end
  end

endmodule

// File: doc/fft_output_serializer.md
FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

Interface
REQ-001 Parameter N, default 32, FFT length; power of two, at least 4.
REQ-002 Parameter word_size, default 16, bit width of each real or imaginary component.
REQ-003 Parameter DEPTH, default 8, FIFO depth in samples; power of two, at least 4.
REQ-004 Parameter AW, default $clog2(N), sample index width.
REQ-005 Clock and reset SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-006 clk  input  1  clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  a sample pair is presented.
REQ-009 in_samp1  input  2*word_size  even-index sample: real in [2W-1:W], imag in [W-1:0].
REQ-010 in_samp2  input  2*word_size  odd-index sample, same packing as in_samp1.
REQ-011 in_addr1  input  AW  index of in_samp1; in_samp2 has index in_addr1|1.
REQ-012 in_ready  output  1  FIFO can accept one pair.
REQ-013 m_ready  input  1  downstream accepts m_data.
REQ-014 m_valid  output  1  m_data is valid.
REQ-015 m_data  output  2*word_size  serialized sample.
REQ-016 m_index  output  AW  FFT bin index of m_data.
REQ-017 m_last  output  1  m_data is bin N-1.
REQ-018 frame_done  output  1  single-cycle pulse after bin N-1 is transferred.
REQ-019 overflow  output  1  sticky flag: a pair was dropped.

Function
REQ-020 Storage SHALL be a circular FIFO of DEPTH entries; each entry holds {sample, index}; occupancy count ranges 0..DEPTH.
REQ-021 in_ready SHALL be combinational and SHALL equal (DEPTH - count >= 2).
REQ-022 A pair SHALL be accepted when in_valid and in_ready are both high: in_samp1 is written at wr_ptr and in_samp2 at wr_ptr+1, both in the same cycle.
REQ-023 When in_valid is high and in_ready is low, the pair SHALL be dropped, the FIFO SHALL remain unchanged, and overflow SHALL be set on the next edge.
REQ-024 m_valid SHALL equal (count != 0); m_data and m_index SHALL be the head entry.
REQ-025 A pop SHALL occur when m_valid and m_ready are both high.
REQ-026 m_data and m_index SHALL hold stable while m_valid is high and m_ready is low.
REQ-027 A simultaneous push of 2 and pop of 1 SHALL update count by +1 in that cycle.
REQ-028 Pointers SHALL wrap modulo DEPTH.
REQ-029 count SHALL never exceed DEPTH and SHALL never underflow.
REQ-030 Data SHALL first appear on the output one cycle after acceptance into an empty FIFO.
REQ-031 The sustained output rate SHALL be one sample per clk.
REQ-032 m_last SHALL be combinational: m_valid and (m_index == N-1).
REQ-033 frame_done SHALL pulse high for exactly one cycle, in the cycle after a pop with m_last high.
REQ-034 Index values SHALL be carried unchanged from in_addr1 and in_addr1|1; no reordering SHALL be applied.

Reset
REQ-035 On reset, wr_ptr, rd_ptr, count, overflow and frame_done SHALL clear to 0.
REQ-036 After reset, m_valid SHALL read 0 and in_ready SHALL read 1.
REQ-037 Reset asserted mid-frame SHALL discard all buffered samples; no stale sample SHALL appear on the output after reset.
REQ-038 FIFO data storage SHALL NOT be reset.

Configuration
REQ-039 With macro FFT_SER_SCALE_EN defined, each component SHALL be arithmetically right-shifted by AW bits, sign-preserving and truncating toward negative infinity, before it is written to the FIFO.
REQ-040 Without FFT_SER_SCALE_EN, samples SHALL be stored unmodified.
REQ-041 Latency and handshake behaviour SHALL be identical in both builds.

Verification
REQ-042 Reset, then 16 pairs with addr 0,2,...,30 and m_ready held high -> m_index 0..31 in order, one per cycle; m_last only at index 31; one frame_done pulse.
REQ-043 m_ready held low, 4 pairs pushed (DEPTH 8) -> count 8, in_ready 0; a 5th pair -> overflow 1 and FIFO contents unchanged.
REQ-044 FIFO full, m_ready toggled 1,0,1 -> exactly 2 pops; head stable while m_ready is low; in_ready rises only when free space is at least 2.
REQ-045 Reset asserted with 5 samples buffered -> next cycle m_valid 0, in_ready 1, overflow 0; a new pair at addr 0 emits indices 0 then 1.
REQ-046 With FFT_SER_SCALE_EN and N 32: input real 0x7FE0, imag 0x8000 -> output real 0x03FF, imag 0xFC00; without the macro -> output equals input.
REQ-047 Random m_ready stall pattern with continuous input paced by in_ready -> all 32 bins output exactly once, in order, with no overflow.
